// File: rtl/gray_count_monitor.sv
// Gray-count consumer: registers the Gray count, converts it to binary, tracks direction/wrap/epoch,
// flags illegal steps and offers a req/ack snapshot. Optional error counter: GRAY_MON_ERRCNT_EN.
module gray_count_monitor #(
    parameter int WIDTH       = 8,
    parameter int EPOCH_WIDTH = 8
) (
    input  logic                   C,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       gray_i,
    input  logic                   snap_req_i,
    input  logic                   snap_ack_i,
    output logic [WIDTH-1:0]       bin_o,
    output logic [EPOCH_WIDTH-1:0] epoch_o,
    output logic                   dir_o,
    output logic                   wrap_o,
    output logic                   step_err_o,
    output logic                   snap_valid_o,
    output logic [WIDTH-1:0]       snap_bin_o,
    output logic [EPOCH_WIDTH-1:0] snap_epoch_o,
    output logic [7:0]             err_cnt_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0]       gray_q_reg;
    logic                   gray_q_valid_reg;
    logic                   primed_reg;
    logic [WIDTH-1:0]       bin_reg;
    logic [EPOCH_WIDTH-1:0] epoch_reg;
    logic                   dir_reg;
    logic                   wrap_reg;
    logic                   step_err_reg;
    logic [0:0]             state_reg;
    logic                   snap_valid_reg;
    logic [WIDTH-1:0]       snap_bin_reg;
    logic [EPOCH_WIDTH-1:0] snap_epoch_reg;

    logic [WIDTH-1:0]       bin_next;
    logic [WIDTH-1:0]       delta;
    logic                   classify;
    logic                   step_up;
    logic                   step_down;
    logic                   step_illegal;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
            assign bin_next[gi] = ^gray_q_reg[WIDTH-1:gi];
        end
    endgenerate

    // gray_q_valid_reg keeps the reset value of gray_q_reg from being taken as a real sample.
    assign classify     = gray_q_valid_reg && primed_reg;
    assign delta        = bin_next - bin_reg;
    assign step_up      = classify && (delta == ONE);
    assign step_down    = classify && (delta == ALL_ONES);
    assign step_illegal = classify && (delta != '0) && !step_up && !step_down;

    always_ff @(posedge C) begin
        if (rst) begin
            gray_q_reg       <= '0;
            gray_q_valid_reg <= 1'b0;
            primed_reg       <= 1'b0;
            bin_reg          <= '0;
            epoch_reg        <= '0;
            dir_reg          <= 1'b0;
            wrap_reg         <= 1'b0;
            step_err_reg     <= 1'b0;
        end else begin
            gray_q_reg       <= gray_i;
            gray_q_valid_reg <= 1'b1;
            bin_reg          <= bin_next;
            wrap_reg         <= 1'b0;
            if (gray_q_valid_reg && !primed_reg) begin
                primed_reg <= 1'b1;
            end
            if (step_up) begin
                dir_reg <= 1'b1;
                if (bin_next == '0) begin
                    epoch_reg <= epoch_reg + 1'b1;
                    wrap_reg  <= 1'b1;
                end
            end
            if (step_down) begin
                dir_reg <= 1'b0;
                if (bin_next == ALL_ONES) begin
                    epoch_reg <= epoch_reg - 1'b1;
                    wrap_reg  <= 1'b1;
                end
            end
            if (step_illegal) begin
                step_err_reg <= 1'b1;
            end
        end
    end

`ifdef GRAY_MON_ERRCNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge C) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (step_illegal && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_reg;
`else
    assign err_cnt_o = '0;
`endif

    // Snapshot captures the outputs visible this cycle, before this edge's update.
    always_ff @(posedge C) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            snap_valid_reg <= 1'b0;
            snap_bin_reg   <= '0;
            snap_epoch_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (snap_req_i) begin
                        snap_bin_reg   <= bin_reg;
                        snap_epoch_reg <= epoch_reg;
                        snap_valid_reg <= 1'b1;
                        state_reg      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (snap_ack_i && snap_req_i) begin
                        snap_bin_reg   <= bin_reg;
                        snap_epoch_reg <= epoch_reg;
                    end else if (snap_ack_i) begin
                        snap_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    snap_valid_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bin_o        = bin_reg;
    assign epoch_o      = epoch_reg;
    assign dir_o        = dir_reg;
    assign wrap_o       = wrap_reg;
    assign step_err_o   = step_err_reg;
    assign snap_valid_o = snap_valid_reg;
    assign snap_bin_o   = snap_bin_reg;
    assign snap_epoch_o = snap_epoch_reg;

endmodule

// File: tb/tb_gray_count_monitor.sv
// Directed bench for gray_count_monitor (WIDTH=4): a reference model pushes expected outputs to a
// queue as each Gray value is driven; they are popped and compared once the 2-cycle pipeline delivers them.
module tb_gray_count_monitor;

    logic       C;
    logic       rst;
    logic [3:0] gray_i;
    logic       snap_req_i;
    logic       snap_ack_i;
    logic [3:0] bin_o;
    logic [7:0] epoch_o;
    logic       dir_o;
    logic       wrap_o;
    logic       step_err_o;
    logic       snap_valid_o;
    logic [3:0] snap_bin_o;
    logic [7:0] snap_epoch_o;
    logic [7:0] err_cnt_o;

    gray_count_monitor #(.WIDTH(4), .EPOCH_WIDTH(8)) dut (
        .C(C), .rst(rst), .gray_i(gray_i), .snap_req_i(snap_req_i), .snap_ack_i(snap_ack_i),
        .bin_o(bin_o), .epoch_o(epoch_o), .dir_o(dir_o), .wrap_o(wrap_o), .step_err_o(step_err_o),
        .snap_valid_o(snap_valid_o), .snap_bin_o(snap_bin_o), .snap_epoch_o(snap_epoch_o),
        .err_cnt_o(err_cnt_o)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic [3:0] bin;
        logic [7:0] epoch;
        logic       dir;
        logic       wrap;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic       m_primed;
    logic [3:0] m_bin;
    logic [7:0] m_epoch;
    logic       m_dir;
    logic       m_err;
    logic [7:0] m_cnt;
    logic [3:0] cur_bin;
    logic [7:0] cur_epoch;
    logic       s_valid;
    logic [3:0] s_bin;
    logic [7:0] s_epoch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] v;
        v = 4'(n);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [3:0] from_gray(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset();
        m_primed = 1'b0; m_bin = '0; m_epoch = '0; m_dir = 1'b0; m_err = 1'b0; m_cnt = '0;
        cur_bin = '0; cur_epoch = '0;
        s_valid = 1'b0; s_bin = '0; s_epoch = '0;
        q.delete();
    endtask

    task automatic model_push(input logic [3:0] g);
        exp_t       e;
        logic [3:0] b;
        logic [3:0] d;
        logic       w;
        b = from_gray(g);
        w = 1'b0;
        if (!m_primed) begin
            m_primed = 1'b1;
        end else begin
            d = b - m_bin;
            if (d == 4'd1) begin
                m_dir = 1'b1;
                if (b == 4'd0) begin m_epoch = m_epoch + 8'd1; w = 1'b1; end
            end else if (d == 4'hF) begin
                m_dir = 1'b0;
                if (b == 4'hF) begin m_epoch = m_epoch - 8'd1; w = 1'b1; end
            end else if (d != 4'd0) begin
                m_err = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
        end
        m_bin = b;
        e.bin = m_bin; e.epoch = m_epoch; e.dir = m_dir; e.wrap = w; e.err = m_err;
`ifdef GRAY_MON_ERRCNT_EN
        e.cnt = m_cnt;
`else
        e.cnt = 8'd0;
`endif
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] g, input logic req, input logic ack);
        exp_t e;
        gray_i = g; snap_req_i = req; snap_ack_i = ack;
        model_push(g);
        if (!s_valid) begin
            if (req) begin s_valid = 1'b1; s_bin = cur_bin; s_epoch = cur_epoch; end
        end else if (ack && req) begin
            s_bin = cur_bin; s_epoch = cur_epoch;
        end else if (ack) begin
            s_valid = 1'b0;
        end
        @(posedge C); #1;
        snap_req_i = 1'b0; snap_ack_i = 1'b0;
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("bin", 32'(bin_o), 32'(e.bin));
            chk("epoch", 32'(epoch_o), 32'(e.epoch));
            chk("dir", 32'(dir_o), 32'(e.dir));
            chk("wrap", 32'(wrap_o), 32'(e.wrap));
            chk("step_err", 32'(step_err_o), 32'(e.err));
            chk("err_cnt", 32'(err_cnt_o), 32'(e.cnt));
            cur_bin = e.bin; cur_epoch = e.epoch;
        end
        chk("snap_valid", 32'(snap_valid_o), 32'(s_valid));
        chk("snap_bin", 32'(snap_bin_o), 32'(s_bin));
        chk("snap_epoch", 32'(snap_epoch_o), 32'(s_epoch));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; gray_i = '0; snap_req_i = 1'b0; snap_ack_i = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge C); #1;
            chk("rst_bin", 32'(bin_o), 32'd0);
            chk("rst_epoch", 32'(epoch_o), 32'd0);
            chk("rst_dir", 32'(dir_o), 32'd0);
            chk("rst_wrap", 32'(wrap_o), 32'd0);
            chk("rst_err", 32'(step_err_o), 32'd0);
            chk("rst_snap_valid", 32'(snap_valid_o), 32'd0);
            chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; gray_i = '0; snap_req_i = 1'b0; snap_ack_i = 1'b0;
        model_reset();
        do_reset(2);

        // Prime with 0, then count up through the wrap
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        for (int n = 1; n < 16; n++) step(to_gray(n), 1'b0, 1'b0);
        step(to_gray(0), 1'b0, 1'b0);

        // Down-wrap 0 -> 15, then 14
        step(to_gray(15), 1'b0, 1'b0);
        step(to_gray(14), 1'b0, 1'b0);

        // Back up through the wrap, then an illegal jump 0 -> 2
        step(to_gray(15), 1'b0, 1'b0);
        step(to_gray(0), 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);

        // 300 more illegal steps to saturate the counter
        for (int i = 0; i < 300; i++) step((i % 2 == 1) ? to_gray(8) : to_gray(0), 1'b0, 1'b0);
        step(to_gray(0), 1'b0, 1'b0);

        // Two more laps: epoch 3, then climb to 5
        for (int lap = 0; lap < 2; lap++) begin
            for (int n = 1; n < 16; n++) step(to_gray(n), 1'b0, 1'b0);
            step(to_gray(0), 1'b0, 1'b0);
        end
        for (int n = 1; n < 6; n++) step(to_gray(n), 1'b0, 1'b0);
        step(to_gray(5), 1'b0, 1'b0);
        step(to_gray(5), 1'b0, 1'b0);

        // Snapshot at bin 5 / epoch 3, ignored re-request, ack
        step(to_gray(5), 1'b1, 1'b0);
        step(to_gray(6), 1'b0, 1'b0);
        step(to_gray(7), 1'b1, 1'b0);
        step(to_gray(8), 1'b0, 1'b0);
        step(to_gray(8), 1'b0, 1'b1);
        step(to_gray(8), 1'b0, 1'b1);

        // Capture at 8, then ack+req together recaptures at 9
        step(to_gray(9), 1'b0, 1'b0);
        step(to_gray(9), 1'b1, 1'b0);
        step(to_gray(9), 1'b1, 1'b1);
        step(to_gray(10), 1'b0, 1'b0);

        // Reset during HOLD, then restart mid-range without error or wrap
        do_reset(1);
        step(to_gray(11), 1'b0, 1'b0);
        step(to_gray(12), 1'b0, 1'b0);
        step(to_gray(12), 1'b0, 1'b0);
        step(to_gray(13), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_count_monitor.md
Name: gray_count_monitor

Overview:
- Consumer stage directly downstream of the Gray counter built from the Gray counter cells.
- Registers the raw Gray count and converts it to binary.
- Tracks direction and wrap-around, and extends the count with an epoch register.
- Flags illegal multi-bit steps and offers a req/ack snapshot of {epoch, binary} to a register-interface reader.

Parameters:
- WIDTH, 8, width of the Gray count input and the binary output.
- EPOCH_WIDTH, 8, width of the wrap (epoch) extension counter.

Ports:
- C  input  1  clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- gray_i  input  WIDTH  Gray count from the upstream counter, in the C domain.
- snap_req_i  input  1  one-cycle snapshot request.
- snap_ack_i  input  1  reader has consumed the snapshot.
- bin_o  output  WIDTH  registered binary count.
- epoch_o  output  EPOCH_WIDTH  wrap count; +1 on up-wrap, -1 on down-wrap.
- dir_o  output  1  direction of the last valid nonzero step; 1 = up.
- wrap_o  output  1  one-cycle pulse on either wrap direction.
- step_err_o  output  1  sticky illegal-step flag.
- snap_valid_o  output  1  snapshot held and valid.
- snap_bin_o  output  WIDTH  captured binary count.
- snap_epoch_o  output  EPOCH_WIDTH  captured epoch.
- err_cnt_o  output  8  illegal-step count (see Optional Feature).

Behaviour:
- Reset is sampled on the C edge. On reset, all outputs and internal registers go to 0, including the prime flag and the snapshot FSM (IDLE).
- Stage 1: gray_q <= gray_i.
- Stage 2: bin_o <= gray2bin(gray_q), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
- Latency from gray_i to bin_o is 2 cycles.
- Step classification is performed on the stage-2 result, comparing the new binary value with the previous bin_o: delta = new - prev, modulo 2^WIDTH.
  - delta 0: hold; nothing changes.
  - delta 1: up step; dir_o <= 1. If prev is all-ones and new is 0: epoch_o + 1 and a wrap_o pulse.
  - delta all-ones (-1): down step; dir_o <= 0. If prev is 0 and new is all-ones: epoch_o - 1 and a wrap_o pulse.
  - Any other delta: illegal step. step_err_o <= 1 (sticky until rst); epoch and dir are unchanged; bin_o still follows the input.
- Prime: the first stage-2 value after reset is loaded without classification and sets the prime flag. No error and no wrap can occur on that cycle.
- Epoch arithmetic is modulo 2^EPOCH_WIDTH and wraps silently.
- wrap_o is registered and aligned with the bin_o update that caused it.
- Snapshot FSM:
  - IDLE: on snap_req_i, capture the current bin_o/epoch_o (values visible in the same cycle, pre-update), set snap_valid_o = 1 next cycle, go to HOLD.
  - HOLD: snap_* outputs are frozen.
    - snap_ack_i alone: snap_valid_o <= 0, go to IDLE.
    - snap_req_i alone: ignored.
    - snap_ack_i and snap_req_i in the same cycle: recapture; snap_valid_o stays 1; remain in HOLD.
  - snap_ack_i in IDLE: ignored.
- Reset asserted mid-HOLD or mid-stream: state returns to IDLE/unprimed next edge. snap_valid_o drops to 0; epoch and error state are cleared.

Optional Feature:
- Macro GRAY_MON_ERRCNT_EN.
- Defined: an 8-bit counter increments on every illegal step, saturates at 255, and is cleared only by rst. err_cnt_o shows the counter.
- Undefined: no counter logic is built; err_cnt_o is tied to 0. step_err_o behaves identically in both builds.

Test Plan:
- WIDTH=4, rst for 2 cycles, then gray_i=0000 held → after rst: bin_o=0, epoch_o=0, step_err_o=0, snap_valid_o=0, err_cnt_o=0.
- Drive the Gray sequence 0→15→0 upward, one step per cycle (15 = 1000) → bin_o tracks 2 cycles late; at 15→0 wrap_o pulses once, epoch_o=1, dir_o=1, no error.
- From bin 0, step gray 0000→1000 (value 15) → wrap_o pulse, epoch_o=0, dir_o=0; continue down to 14 (1001) → no wrap, no error.
- gray 0000→0011 (value 2) → step_err_o=1 and stays 1; epoch and dir unchanged; err_cnt_o=1 with the macro, 0 without. Force 300 illegal steps → err_cnt_o=255.
- At bin 5, epoch 3, pulse snap_req_i → snap_valid_o=1 next cycle with snap_bin_o=5, snap_epoch_o=3. These stay frozen while the count advances; a second req is ignored; snap_ack_i drops valid.
- In HOLD, assert ack and req together at bin 9 → valid stays 1, snap_bin_o=9. Assert rst during HOLD → snap_valid_o=0 next edge; the first post-reset sample produces no error and no wrap.
